// File: rtl/aec_pkg.sv
// Shared types and constants for the stack calculator: FSM states, ASCII codes,
// operator encoding and the postfix token format.
package aec_pkg;

   typedef enum logic [2:0] {IDLE, RECV, FLUSH, EVAL, DONE} state_t;

   localparam logic [7:0] CH_0   = 8'h30;
   localparam logic [7:0] CH_9   = 8'h39;
   localparam logic [7:0] CH_A   = 8'h61;
   localparam logic [7:0] CH_F   = 8'h66;
   localparam logic [7:0] CH_ADD = 8'h2B;
   localparam logic [7:0] CH_SUB = 8'h2D;
   localparam logic [7:0] CH_MUL = 8'h2A;
   localparam logic [7:0] CH_LP  = 8'h28;
   localparam logic [7:0] CH_RP  = 8'h29;
   localparam logic [7:0] CH_EQ  = 8'h3D;

   typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_LP} op_t;

   localparam int TOK_VW = 4;

   typedef struct packed {
      logic              is_op;
      logic [TOK_VW-1:0] val;
   } token_t;

   // '(' ranks lowest so it is never popped by an incoming operator
   function automatic logic [1:0] prec(input logic [1:0] op);
      case (op)
         OP_MUL:  prec = 2'd2;
         OP_LP:   prec = 2'd0;
         default: prec = 2'd1;
      endcase
   endfunction

   function automatic token_t op_tok(input logic [1:0] op);
      return '{is_op: 1'b1, val: {2'b00, op}};
   endfunction

endpackage

// File: rtl/aec_lifo.sv
// Parametrised LIFO with top/second-from-top visibility; pops (0..3) are
// applied before a push in the same cycle.
module aec_lifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       push,
   input  logic [1:0]                 pop,
   input  logic [DW-1:0]              din,
   output logic [DW-1:0]              top,
   output logic [DW-1:0]              below,
   output logic [$clog2(DEPTH+1)-1:0] cnt,
   output logic                       full,
   output logic                       empty
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem [DEPTH];
   logic [CW-1:0] sp, base;
   logic          wr;

   always_comb begin
      base = (CW'(pop) > sp) ? '0 : sp - CW'(pop);
      wr   = push && (int'(base) < DEPTH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     sp <= '0;
      else if (clr) sp <= '0;
      else          sp <= base + CW'(wr);
   end

   always_ff @(posedge clk) begin
      if (wr) mem[AW'(base)] <= din;
   end

   assign top   = (sp != '0)     ? mem[AW'(sp - CW'(1))] : '0;
   assign below = (sp > CW'(1))  ? mem[AW'(sp - CW'(2))] : '0;
   assign cnt   = sp;
   assign full  = (int'(sp) == DEPTH);
   assign empty = (sp == '0);

endmodule

// File: rtl/aec_stack_calc.sv
// Streaming infix calculator: shunting-yard to a postfix buffer while
// characters arrive, then flush and evaluate on an operand stack.
module aec_stack_calc #(
   parameter int W      = 7,
   parameter int DEPTH  = 16,
   parameter int HEX_EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ready,
   input  logic [7:0]   ascii_in,
   output logic         valid,
   output logic [W-1:0] result,
   output logic         err
);
   import aec_pkg::*;

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t         state, state_nx;
   token_t         pf [DEPTH];
   token_t         pf_t0, pf_t1, tk;
   logic [1:0]     pf_n;
   logic [CW-1:0]  wp, wp_nx, rp, rp_nx, pdepth, pd_nx;
   logic           err_r, err_nx, clr;
   logic           fin, fin_err;
   logic [W-1:0]   fin_res;

   logic           op_push, op_full, op_empty;
   logic [1:0]     op_pop, op_din, op_top, op_below;
   logic [CW-1:0]  op_cnt;
   logic           n_push, n_full, n_empty;
   logic [1:0]     n_pop;
   logic [W-1:0]   n_din, n_top, n_below;
   logic [CW-1:0]  n_cnt;

   logic           is_dig, is_hex, is_opc;
   logic [3:0]     dval;
   logic [1:0]     cop;
   logic           unused_flags;

   assign unused_flags = ^{n_full, n_empty};

   aec_lifo #(.DW(2), .DEPTH(DEPTH)) u_ops (
      .clk(clk), .rst(rst), .clr(clr), .push(op_push), .pop(op_pop), .din(op_din),
      .top(op_top), .below(op_below), .cnt(op_cnt), .full(op_full), .empty(op_empty));

   aec_lifo #(.DW(W), .DEPTH(DEPTH)) u_nums (
      .clk(clk), .rst(rst), .clr(clr), .push(n_push), .pop(n_pop), .din(n_din),
      .top(n_top), .below(n_below), .cnt(n_cnt), .full(n_full), .empty(n_empty));

   always_comb begin
      is_dig = (ascii_in >= CH_0) && (ascii_in <= CH_9);
      is_hex = (HEX_EN != 0) && (ascii_in >= CH_A) && (ascii_in <= CH_F);
      dval   = is_dig ? 4'(ascii_in - CH_0) : 4'(ascii_in - CH_A + 8'd10);
      is_opc = 1'b1;
      case (ascii_in)
         CH_ADD:  cop = OP_ADD;
         CH_SUB:  cop = OP_SUB;
         CH_MUL:  cop = OP_MUL;
         default: begin cop = OP_ADD; is_opc = 1'b0; end
      endcase
   end

   always_comb begin
      state_nx = state;
      err_nx   = err_r;
      rp_nx    = rp;
      pd_nx    = pdepth;
      clr      = 1'b0;
      op_push  = 1'b0;
      op_pop   = 2'd0;
      op_din   = OP_ADD;
      n_push   = 1'b0;
      n_pop    = 2'd0;
      n_din    = '0;
      pf_n     = 2'd0;
      pf_t0    = '0;
      pf_t1    = '0;
      tk       = '0;
      fin      = 1'b0;
      fin_err  = 1'b0;
      fin_res  = '0;
      case (state)
         IDLE, RECV: if (state == RECV || ready) begin
            state_nx = RECV;
            if (ascii_in == CH_EQ) begin
               if (err_r) begin
                  state_nx = DONE; fin = 1'b1; fin_err = 1'b1;
               end else begin
                  state_nx = FLUSH;
               end
            end else if (is_dig || is_hex) begin
               pf_n  = 2'd1;
               pf_t0 = '{is_op: 1'b0, val: dval};
            end else if (ascii_in == CH_LP) begin
               op_push = 1'b1; op_din = OP_LP; pd_nx = pdepth + 1;
            end else if (ascii_in == CH_RP) begin
               // above the innermost '(' at most two operators of rising precedence
               if (pdepth == '0) err_nx = 1'b1;
               else begin
                  pd_nx = pdepth - 1;
                  if (op_top == OP_LP) op_pop = 2'd1;
                  else if (op_below == OP_LP) begin
                     op_pop = 2'd2; pf_n = 2'd1; pf_t0 = op_tok(op_top);
                  end else begin
                     op_pop = 2'd3; pf_n = 2'd2;
                     pf_t0 = op_tok(op_top); pf_t1 = op_tok(op_below);
                  end
               end
            end else if (is_opc) begin
               op_push = 1'b1; op_din = cop;
               if (op_cnt != '0 && prec(op_top) >= prec(cop)) begin
                  pf_t0 = op_tok(op_top);
                  if (int'(op_cnt) >= 2 && prec(op_below) >= prec(cop)) begin
                     op_pop = 2'd2; pf_n = 2'd2; pf_t1 = op_tok(op_below);
                  end else begin
                     op_pop = 2'd1; pf_n = 2'd1;
                  end
               end
            end else begin
               err_nx = 1'b1;
            end
            if (op_push && (int'(op_cnt) - int'(op_pop) >= DEPTH)) begin
               err_nx = 1'b1; op_push = 1'b0; pd_nx = pdepth;
            end
            if (int'(wp) + int'(pf_n) > DEPTH) begin
               err_nx = 1'b1; pf_n = 2'd0;
            end
         end
         FLUSH: begin
            if (op_empty) state_nx = EVAL;
            else if (op_top == OP_LP || int'(wp) == DEPTH || op_full && 1'b0) begin
               state_nx = DONE; fin = 1'b1; fin_err = 1'b1;
            end else begin
               op_pop = 2'd1; pf_n = 2'd1; pf_t0 = op_tok(op_top);
            end
         end
         EVAL: begin
            if (rp == wp) begin
               state_nx = DONE; fin = 1'b1;
               if (int'(n_cnt) == 1) fin_res = n_top;
               else                  fin_err = 1'b1;
            end else begin
               tk    = pf[AW'(rp)];
               rp_nx = rp + 1;
               if (!tk.is_op) begin
                  n_push = 1'b1; n_din = W'(tk.val);
               end else if (int'(n_cnt) < 2) begin
                  state_nx = DONE; fin = 1'b1; fin_err = 1'b1;
               end else begin
                  n_pop = 2'd2; n_push = 1'b1;
                  case (tk.val[1:0])
                     OP_ADD:  n_din = n_below + n_top;
                     OP_SUB:  n_din = n_below - n_top;
                     default: n_din = n_below * n_top;
                  endcase
               end
            end
         end
         DONE: begin
            state_nx = IDLE; clr = 1'b1; err_nx = 1'b0;
            rp_nx = '0; pd_nx = '0;
         end
         default: state_nx = IDLE;
      endcase
      wp_nx = (state == DONE) ? '0 : wp + CW'(pf_n);
   end

   always_ff @(posedge clk) begin
      if (pf_n != 2'd0) pf[AW'(wp)]     <= pf_t0;
      if (pf_n == 2'd2) pf[AW'(wp + 1)] <= pf_t1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         err_r  <= 1'b0;
         wp     <= '0;
         rp     <= '0;
         pdepth <= '0;
         valid  <= 1'b0;
         result <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_nx;
         err_r  <= err_nx;
         wp     <= wp_nx;
         rp     <= rp_nx;
         pdepth <= pd_nx;
         valid  <= fin;
         if (fin) begin
            err    <= fin_err;
            result <= fin_err ? '0 : fin_res;
         end
      end
   end

endmodule

// File: tb/tb_aec_stack_calc.sv
// Three calculator instances (default, no-hex, shallow) share one character
// stream and are checked against a queue-based expression model.
module tb_aec_stack_calc;
   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ready = 1'b0;
   logic [7:0] ascii_in = 8'h00;
   logic       vv [NI];
   logic [6:0] rr [NI];
   logic       ee [NI];

   int total = 0, bad = 0, cyc = 0;
   int nv  [NI] = '{0, 0, 0};
   int dbl [NI] = '{0, 0, 0};
   logic pv [NI] = '{1'b0, 1'b0, 1'b0};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aec_stack_calc #(.W(7), .DEPTH(16), .HEX_EN(1)) dut0 (.clk(clk), .rst(rst), .ready(ready),
      .ascii_in(ascii_in), .valid(vv[0]), .result(rr[0]), .err(ee[0]));
   aec_stack_calc #(.W(7), .DEPTH(16), .HEX_EN(0)) dut1 (.clk(clk), .rst(rst), .ready(ready),
      .ascii_in(ascii_in), .valid(vv[1]), .result(rr[1]), .err(ee[1]));
   aec_stack_calc #(.W(7), .DEPTH(4), .HEX_EN(1)) dut2 (.clk(clk), .rst(rst), .ready(ready),
      .ascii_in(ascii_in), .valid(vv[2]), .result(rr[2]), .err(ee[2]));

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (vv[i]) nv[i] <= nv[i] + 1;
         if (vv[i] && pv[i]) dbl[i] <= dbl[i] + 1;
         pv[i] <= vv[i];
      end
   end

   function automatic int dep_of(input int i);
      return (i == 2) ? 4 : 16;
   endfunction

   function automatic bit hex_of(input int i);
      return (i != 1);
   endfunction

   function automatic int pr(input int c);
      return (c == 42) ? 2 : 1;
   endfunction

   // Textbook shunting-yard plus stack evaluation with the capacity limits.
   function automatic void model(input string s, input int dep, input bit hex,
                                 output bit e, output int r);
      int ops[$]; int pf[$]; int st[$];
      int c, t, a, b, v;
      bit found;
      e = 0; r = 0;
      for (int k = 0; k < s.len(); k++) begin
         c = int'(s[k]);
         if (c == 61) break;
         if (c >= 48 && c <= 57 || hex && c >= 97 && c <= 102) begin
            v = (c <= 57) ? c - 48 : c - 87;
            if (pf.size() >= dep) e = 1; else pf.push_back(v);
         end else if (c == 40) begin
            if (ops.size() >= dep) e = 1; else ops.push_back(c);
         end else if (c == 41) begin
            found = 0;
            while (ops.size() > 0) begin
               t = ops.pop_back();
               if (t == 40) begin found = 1; break; end
               if (pf.size() >= dep) e = 1; else pf.push_back(t);
            end
            if (!found) e = 1;
         end else if (c == 43 || c == 45 || c == 42) begin
            while (ops.size() > 0 && ops[$] != 40 && pr(ops[$]) >= pr(c)) begin
               t = ops.pop_back();
               if (pf.size() >= dep) e = 1; else pf.push_back(t);
            end
            if (ops.size() >= dep) e = 1; else ops.push_back(c);
         end else e = 1;
      end
      while (!e && ops.size() > 0) begin
         t = ops.pop_back();
         if (t == 40) e = 1;
         else if (pf.size() >= dep) e = 1;
         else pf.push_back(t);
      end
      if (e) return;
      foreach (pf[k]) begin
         if (pf[k] < 16) st.push_back(pf[k]);
         else begin
            if (st.size() < 2) begin e = 1; break; end
            b = st.pop_back(); a = st.pop_back();
            case (pf[k])
               43:      v = a + b;
               45:      v = a - b;
               default: v = a * b;
            endcase
            st.push_back(v & 127);
         end
      end
      if (!e && st.size() != 1) e = 1;
      r = e ? 0 : st[0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic run_expr(input string s, input bit noise);
      bit me[NI]; int mr[NI]; int seen[NI]; int lat[NI];
      logic [6:0] cr[NI]; logic ce[NI];
      int eqc; bit all;
      for (int i = 0; i < NI; i++) begin
         model(s, dep_of(i), hex_of(i), me[i], mr[i]);
         seen[i] = 0; lat[i] = 0; cr[i] = 'x; ce[i] = 'x;
      end
      for (int k = 0; k < s.len(); k++) begin
         @(negedge clk);
         ascii_in = s[k];
         ready = (k == 0) ? 1'b1 : (noise ? 1'($urandom_range(0, 1)) : 1'b0);
      end
      eqc = cyc;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (t == 0) begin ready = 1'b0; ascii_in = 8'($urandom); end
         all = 1;
         for (int i = 0; i < NI; i++) begin
            if (vv[i]) begin seen[i]++; cr[i] = rr[i]; ce[i] = ee[i]; lat[i] = cyc - eqc - 1; end
            if (seen[i] == 0) all = 0;
         end
         if (all) break;
      end
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("u%0d %s valid", i, s), seen[i], 1);
         chk($sformatf("u%0d %s err", i, s), ce[i], me[i]);
         chk($sformatf("u%0d %s result", i, s), cr[i], mr[i]);
         chk($sformatf("u%0d %s held", i, s), rr[i], mr[i]);
         if (seen[i] > 0)
            chk($sformatf("u%0d %s latency", i, s), lat[i] <= 2 * dep_of(i) + 3, 1);
      end
   endtask

   function automatic string gen_valid();
      string s = "";
      string dig = "0123456789abcdef";
      string opc = "+-*";
      int n = $urandom_range(1, 6);
      int open = 0;
      for (int t = 0; t < n; t++) begin
         if ($urandom_range(0, 3) == 0 && open < 3) begin s = {s, "("}; open++; end
         s = {s, $sformatf("%c", dig[$urandom_range(0, 15)])};
         if (open > 0 && $urandom_range(0, 2) == 0) begin s = {s, ")"}; open--; end
         if (t < n - 1) s = {s, $sformatf("%c", opc[$urandom_range(0, 2)])};
      end
      while (open > 0) begin s = {s, ")"}; open--; end
      return {s, "="};
   endfunction

   function automatic string gen_junk();
      string s = "";
      string alph = "0123456789abcdef+-*()xA ";
      int n = $urandom_range(1, 8);
      for (int t = 0; t < n; t++)
         s = {s, $sformatf("%c", alph[$urandom_range(0, alph.len() - 1)])};
      return {s, "="};
   endfunction

   int snap [NI];
   string abort_s;

   initial begin
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("u%0d reset valid", i), vv[i], 0);
         chk($sformatf("u%0d reset err", i), ee[i], 0);
         chk($sformatf("u%0d reset result", i), rr[i], 0);
      end
      @(negedge clk); rst = 1'b1;
      repeat (2) @(negedge clk);

      run_expr("3+4*2=", 0);
      repeat (2) @(negedge clk);
      run_expr("(3+4)*2=", 0);
      run_expr("2-5=", 0);
      run_expr("f*f=", 0);
      run_expr("(((((1)))))=", 0);
      run_expr("((((1))))=", 0);
      run_expr("7*6-3*4=", 1);

      // abort mid-expression with a reset
      @(negedge clk); #1;
      for (int i = 0; i < NI; i++) snap[i] = nv[i];
      abort_s = "9*9*";
      for (int k = 0; k < abort_s.len(); k++) begin
         @(negedge clk);
         ascii_in = abort_s[k];
         ready = (k == 0);
      end
      @(negedge clk); rst = 1'b0; ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("u%0d abort valid", i), vv[i], 0);
         chk($sformatf("u%0d abort result", i), rr[i], 0);
      end
      @(negedge clk); rst = 1'b1;
      repeat (5) @(negedge clk); #1;
      for (int i = 0; i < NI; i++) chk($sformatf("u%0d abort no pulse", i), nv[i], snap[i]);
      run_expr("1+1=", 0);

      // back-to-back: next ready lands the cycle after valid
      run_expr("7*3=", 1);
      run_expr("8-9=", 1);
      run_expr("(1+2)*(3+4)=", 1);

      for (int n = 0; n < 40; n++) begin
         run_expr(gen_valid(), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      for (int n = 0; n < 20; n++) begin
         run_expr(gen_junk(), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk); #1;
      for (int i = 0; i < NI; i++) chk($sformatf("u%0d single-cycle valid", i), dbl[i], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/aec_stack_calc.md
AEC_STACK_CALC -- requirements
Module: aec_stack_calc

Interface
REQ-001 SHALL have parameter W, default 7: result width in bits; all arithmetic is modulo 2^W.
REQ-002 SHALL have parameter DEPTH, default 16: entries in each internal stack and in the postfix buffer.
REQ-003 SHALL have parameter HEX_EN, default 1: when 1, characters 'a'-'f' are operands of value 10-15; when 0, they are illegal.
REQ-004 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port ready, input, 1: marks ascii_in as the first character of a new expression.
REQ-007 SHALL have port ascii_in, input, 8: one expression character per cycle.
REQ-008 SHALL have port valid, output, 1: one-cycle pulse qualifying result and err.
REQ-009 SHALL have port result, output, W: expression value.
REQ-010 SHALL have port err, output, 1: expression rejected, qualified by valid.

Function
REQ-011 SHALL accept characters '0'-'9', 'a'-'f' (HEX_EN=1), '+', '-', '*', '(', ')', and '=' as terminator; every operand is a single character.
REQ-012 SHALL implement FSM states IDLE, RECV, FLUSH, EVAL, DONE.
REQ-013 IDLE->RECV when ready=1; the character sampled in that same cycle is processed.
REQ-014 In RECV, SHALL consume exactly one character per cycle, with no stalls, until '='; then RECV->FLUSH.
REQ-015 In RECV, SHALL convert infix to postfix (shunting-yard): '*' above '+'/'-'; all operators left-associative; parentheses override precedence.
REQ-016 In FLUSH, SHALL pop one remaining operator per cycle into the postfix buffer; on stack empty, FLUSH->EVAL.
REQ-017 In EVAL, SHALL process one postfix token per cycle on an operand stack.
REQ-018 '-' SHALL wrap modulo 2^W; '*' SHALL keep the low W bits of the product.
REQ-019 After the final token, EVAL->DONE; in DONE, valid=1 for exactly one cycle, then DONE->IDLE.
REQ-020 Latency from the '=' cycle to valid SHALL NOT exceed 2*DEPTH+3 cycles.
REQ-021 result and err SHALL hold their values until the next valid pulse.
REQ-022 ready outside IDLE SHALL be ignored.
REQ-023 The following SHALL set a sticky error flag while reception continues to '=': illegal character, operator-stack push when full, postfix-buffer write when full, or ')' with no matching '('.
REQ-024 SHALL also set the error flag for '(' left unmatched at FLUSH, or operand-stack underflow or a final operand depth other than 1 during EVAL.
REQ-025 On error, SHALL skip EVAL, go directly to DONE, and present valid=1, err=1, result=0.
REQ-026 A stack at exactly DEPTH entries SHALL still be legal; only the (DEPTH+1)th push is an error.

Reset
REQ-027 When rst=0, SHALL asynchronously force state IDLE, all stack and buffer pointers to 0, valid=0, err=0, and result=0.
REQ-028 Reset mid-expression SHALL discard all partial state; after release, the next ready starts a clean expression.

Structure
REQ-029 Shared package aec_pkg SHALL hold the FSM state enum, ASCII character constants, operator encoding, and a token typedef (is_op flag plus value field).
REQ-030 SHALL contain one parametrised sub-module, aec_lifo (push/pop/top/full/empty), instantiated for both the operator stack and the operand stack.
REQ-031 The postfix buffer SHALL be a write-pointer array local to aec_stack_calc.

Verification
REQ-032 W=7: "3+4*2=" -> valid pulse, result=11, err=0.
REQ-033 W=7: "(3+4)*2=" -> result=14; then "2-5=" -> result=125 (wrap).
REQ-034 W=7, HEX_EN=1: "f*f=" -> result=97; with HEX_EN=0 the same input -> err=1, result=0.
REQ-035 DEPTH=4: "(((((1)))))=" -> err=1, result=0; "((((1))))=" -> result=1, err=0.
REQ-036 Drive rst=0 mid "9*9*", release, then "1+1=" -> result=2, err=0, and no valid pulse during or after the aborted expression.
REQ-037 Back-to-back expressions with ready asserted the cycle after valid -> both results correct; ready pulses during RECV have no effect.
